kpyd_voice_sequencer: RTL and testbench

- Sequences sample playback for the keypad sound path. Four keypad voices (A, B, 3, 6) share one synchronous sample ROM read port.
- Decides which voice owns the ROM, walks that voice's address range with wrap-around, and presents 24-bit samples to the downstream audio sink over a valid/ready handshake.
- Sits between the keypad decode and the DAC/serializer. Replaces the per-voice free-running counters.

---
 rtl/kpyd_voice_pkg.sv | 24 ++
 rtl/kpyd_onehot_decode.sv | 23 ++
 rtl/kpyd_voice_sequencer.sv | 114 +++++++++++
 tb/tb_kpyd_voice_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/kpyd_voice_pkg.sv
// Shared types and the per-voice ROM address table for the keypad sound path.
package kpyd_voice_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int NUM_VOICES   = 4;
  localparam int VOICE_ADDR_W = 8;

  localparam int VOICE_A = 0;
  localparam int VOICE_B = 1;
  localparam int VOICE_3 = 2;
  localparam int VOICE_6 = 3;

  // Packed so that [v] selects voice v directly.
  localparam logic [NUM_VOICES-1:0][VOICE_ADDR_W-1:0] BASE_ADDR =
    {8'd110, 8'd94, 8'd59, 8'd0};
  localparam logic [NUM_VOICES-1:0][VOICE_ADDR_W-1:0] LAST_ADDR =
    {8'd125, 8'd109, 8'd93, 8'd58};

endpackage

// File: rtl/kpyd_onehot_decode.sv
// Flags a legal key request (exactly one key down) and reports which voice it is.
module kpyd_onehot_decode #(
  parameter int num_voices_p = 4,
  localparam int IW = (num_voices_p > 1) ? $clog2(num_voices_p) : 1
) (
  input  logic [num_voices_p-1:0] kpyd_i,
  output logic                    legal_o,
  output logic [IW-1:0]           idx_o
);

  localparam logic [num_voices_p-1:0] ONE = {{(num_voices_p-1){1'b0}}, 1'b1};

  // Non-zero with no second bit: clearing the lowest set bit leaves nothing.
  assign legal_o = (kpyd_i != '0) && ((kpyd_i & (kpyd_i - ONE)) == '0);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < num_voices_p; i++) begin
      if (kpyd_i[i]) idx_o = i[IW-1:0];
    end
  end

endmodule

// File: rtl/kpyd_voice_sequencer.sv
// Arbitrates the shared sample ROM between keypad voices and streams the active
// voice's samples, looping over its address range, to the audio sink.
module kpyd_voice_sequencer
  import kpyd_voice_pkg::*;
#(
  parameter int width_p      = 24,
  parameter int addr_width_p = 8,
  parameter int num_voices_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [num_voices_p-1:0] kpyd_i,
  output logic [addr_width_p-1:0] rom_addr_o,
  input  logic [width_p-1:0]      rom_data_i,
  output logic [width_p-1:0]      sound_o,
  output logic                    sound_valid_o,
  input  logic                    sound_ready_i,
  output logic [num_voices_p-1:0] voice_o,
  output logic                    wrap_o
);

  localparam int VIW = (num_voices_p > 1) ? $clog2(num_voices_p) : 1;

  logic           key_legal;
  logic [VIW-1:0] key_idx;

  kpyd_onehot_decode #(.num_voices_p(num_voices_p)) u_dec (
    .kpyd_i  (kpyd_i),
    .legal_o (key_legal),
    .idx_o   (key_idx)
  );

  state_e                  state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [width_p-1:0]      sound_q, sound_d;
  logic                    valid_q, valid_d;
  logic [VIW-1:0]          vidx_q, vidx_d;

  function automatic logic [addr_width_p-1:0] base_of(input logic [VIW-1:0] v);
    return addr_width_p'(BASE_ADDR[v]);
  endfunction

  function automatic logic [addr_width_p-1:0] last_of(input logic [VIW-1:0] v);
    return addr_width_p'(LAST_ADDR[v]);
  endfunction

  logic handshake, at_last, same_key;
  assign handshake = (state_q == HOLD) && sound_ready_i;
  assign at_last   = (addr_q == last_of(vidx_q));
  assign same_key  = key_legal && (key_idx == vidx_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sound_d = sound_q;
    valid_d = valid_q;
    vidx_d  = vidx_q;
    unique case (state_q)
      IDLE: begin
        if (key_legal) begin
          vidx_d  = key_idx;
          addr_d  = base_of(key_idx);
          state_d = FETCH;
        end
      end
      FETCH: begin
        sound_d = rom_data_i;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (sound_ready_i) begin
          valid_d = 1'b0;
          if (same_key) begin
            // Wrap by table compare so no address outside the voice is issued.
            addr_d  = at_last ? base_of(vidx_q) : addr_q + addr_width_p'(1);
            state_d = FETCH;
          end else begin
            sound_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sound_q <= '0;
      valid_q <= 1'b0;
      vidx_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sound_q <= sound_d;
      valid_q <= valid_d;
      vidx_q  <= vidx_d;
    end
  end

  always_comb begin
    voice_o = '0;
    if (state_q != IDLE) voice_o[vidx_q] = 1'b1;
  end

  assign rom_addr_o    = addr_q;
  assign sound_o       = sound_q;
  assign sound_valid_o = valid_q;
  assign wrap_o        = handshake && at_last;

endmodule

// File: tb/tb_kpyd_voice_sequencer.sv
// Self-checking bench: directed scenarios plus random key/ready traffic, all
// checked every cycle against an offset-based playback model.
module tb_kpyd_voice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  kpyd = 4'b0000;
  logic        ready = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] sound;
  logic        valid;
  logic [3:0]  voice;
  logic        wrap;
  logic        tb_legal;
  logic [1:0]  tb_idx;

  int errors = 0;
  int checks = 0;
  int wrap_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A};
  endfunction

  assign rom_data = rom_f(rom_addr);

  kpyd_voice_sequencer dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .kpyd_i        (kpyd),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .sound_o       (sound),
    .sound_valid_o (valid),
    .sound_ready_i (ready),
    .voice_o       (voice),
    .wrap_o        (wrap)
  );

  kpyd_onehot_decode #(.num_voices_p(4)) u_tbdec (
    .kpyd_i  (kpyd),
    .legal_o (tb_legal),
    .idx_o   (tb_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which voice is playing, offset within its range, phase.
  int mbase [4] = '{0, 59, 94, 110};
  int mlen  [4] = '{59, 35, 16, 16};
  int m_ph = 0;   // 0 silent, 1 waiting on ROM, 2 sample presented
  int m_v = 0;
  int m_off = 0;
  int m_addr = 0;

  function automatic int idx_of(input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_v <= 0; m_off <= 0; m_addr <= 0;
    end else begin
      case (m_ph)
        0: if ($countones(kpyd) == 1) begin
             m_v <= idx_of(kpyd); m_off <= 0; m_addr <= mbase[idx_of(kpyd)]; m_ph <= 1;
           end
        1: m_ph <= 2;
        default: if (ready) begin
             if ($countones(kpyd) == 1 && idx_of(kpyd) == m_v) begin
               m_off  <= (m_off + 1) % mlen[m_v];
               m_addr <= mbase[m_v] + (m_off + 1) % mlen[m_v];
               m_ph   <= 1;
             end else begin
               m_ph <= 0;
             end
           end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("valid", {31'd0, valid}, {31'd0, m_ph == 2});
    chk("voice", {28'd0, voice}, (m_ph == 0) ? 32'd0 : (32'd1 << m_v));
    chk("rom_addr", {24'd0, rom_addr}, m_addr);
    chk("wrap", {31'd0, wrap}, {31'd0, (m_ph == 2) && ready && (m_off == mlen[m_v] - 1)});
    if (m_ph == 2) chk("sound_hold", {8'd0, sound}, {8'd0, rom_f(m_addr[7:0])});
    if (m_ph == 0) chk("sound_idle", {8'd0, sound}, 32'd0);
    chk("dec_legal", {31'd0, tb_legal}, {31'd0, $countones(kpyd) == 1});
    if ($countones(kpyd) == 1) chk("dec_idx", {30'd0, tb_idx}, idx_of(kpyd));
    if (wrap) wrap_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] held_addr;
  int budget;

  initial begin
    // Reset and idle
    step(3);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_sound", {8'd0, sound}, 32'd0);
    chk("rst_voice", {28'd0, voice}, 32'd0);
    #3 rst_n = 1'b1;
    step(20);
    chk("idle_addr", {24'd0, rom_addr}, 32'd0);

    // Voice A full loop with ready high
    wrap_cnt = 0;
    kpyd = 4'b0001; ready = 1'b1;
    step(2);
    chk("a_first_valid", {31'd0, valid}, 32'd1);
    chk("a_first_sound", {8'd0, sound}, 32'h0000FF5A);
    chk("a_voice", {28'd0, voice}, 32'h1);
    step(120);
    chk("a_wrapped_addr", {24'd0, rom_addr}, 32'd1);
    chk("a_wrap_count", wrap_cnt, 32'd1);
    kpyd = 4'b0000;
    step(3);

    // Voice B with ready held low for 5 cycles
    kpyd = 4'b0010; ready = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_valid", {31'd0, valid}, 32'd1);
      chk("b_hold_sound", {8'd0, sound}, 32'h003BC461);
      if (i < 4) step(1);
    end
    ready = 1'b1;
    step(1);
    chk("b_next_addr", {24'd0, rom_addr}, 32'd60);
    kpyd = 4'b0000;
    step(3);

    // A to address 10, then switch to B on the handshake
    kpyd = 4'b0001; ready = 1'b1;
    budget = 60;
    while (!(valid && rom_addr == 8'd10) && budget > 0) begin step(1); budget--; end
    chk("sw_reach10_timeout", {31'd0, budget > 0}, 32'd1);
    kpyd = 4'b0010;
    step(1);
    chk("sw_idle_valid", {31'd0, valid}, 32'd0);
    chk("sw_idle_voice", {28'd0, voice}, 32'd0);
    step(1);
    chk("sw_b_addr", {24'd0, rom_addr}, 32'd59);
    kpyd = 4'b0000;
    step(4);

    // Illegal multi-key combinations, then voice 6 loop
    held_addr = rom_addr;
    kpyd = 4'b0011; step(5);
    chk("multi2_addr", {24'd0, rom_addr}, {24'd0, held_addr});
    kpyd = 4'b1111; step(5);
    chk("multi4_addr", {24'd0, rom_addr}, {24'd0, held_addr});
    chk("multi4_valid", {31'd0, valid}, 32'd0);
    wrap_cnt = 0;
    kpyd = 4'b1000;
    step(1);
    chk("v6_first_addr", {24'd0, rom_addr}, 32'd110);
    step(1);
    chk("v6_first_sound", {8'd0, sound}, 32'h006E9134);
    step(32);
    chk("v6_wrap_addr", {24'd0, rom_addr}, 32'd110);
    chk("v6_wrap_count", wrap_cnt, 32'd1);

    // Random traffic
    kpyd = 4'b0001 << $urandom_range(0, 3);
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) kpyd = 4'b0000;
      else if (r == 1) kpyd = 4'($urandom);
      else if (r == 2) kpyd = 4'b0001 << $urandom_range(0, 3);
      ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    kpyd = 4'b0000; ready = 1'b1;
    step(4);

    // Async reset in the middle of HOLD
    kpyd = 4'b0100; ready = 1'b0;
    step(2);
    chk("r_pre_valid", {31'd0, valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_valid", {31'd0, valid}, 32'd0);
    chk("r_async_sound", {8'd0, sound}, 32'd0);
    chk("r_async_addr", {24'd0, rom_addr}, 32'd0);
    chk("r_async_voice", {28'd0, voice}, 32'd0);
    chk("r_async_wrap", {31'd0, wrap}, 32'd0);
    #3 rst_n = 1'b1;
    ready = 1'b1;
    step(1);
    chk("r_restart_addr", {24'd0, rom_addr}, 32'd94);
    chk("r_restart_voice", {28'd0, voice}, 32'h4);
    step(1);
    chk("r_restart_sound", {8'd0, sound}, 32'h005EA104);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
